// File: rtl/sdc_pkg.sv
// Shared types for the SD data-response receiver: FSM encoding, CRC status
// token codes and the token decode used to build the status levels.
package sdc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_ST = 3'd1,
    STAT    = 3'd2,
    ENDB    = 3'd3,
    RESP    = 3'd4,
    BUSY    = 3'd5
  } rcv_state_e;

  localparam logic [2:0] TOK_ACCEPT  = 3'b010;
  localparam logic [2:0] TOK_CRC_ERR = 3'b101;
  localparam logic [2:0] TOK_WR_ERR  = 3'b110;

  typedef struct packed {
    logic crc_ok;
    logic crc_err;
    logic wr_err;
    logic frm_err;
  } tok_stat_t;

  // Only an accept needs a good end bit; the error codes are reported as seen
  // so the controller still learns what the card tried to say.
  function automatic tok_stat_t tok_decode(input logic [2:0] code, input logic end_ok);
    tok_stat_t s;
    s.crc_ok  = end_ok && (code == TOK_ACCEPT);
    s.crc_err = (code == TOK_CRC_ERR);
    s.wr_err  = (code == TOK_WR_ERR);
    s.frm_err = !end_ok || !(code inside {TOK_ACCEPT, TOK_CRC_ERR, TOK_WR_ERR});
    return s;
  endfunction

endpackage

// File: rtl/sdc_dat_resp_rcv_if.sv
// Handshake between the write controller (master) and the response receiver
// (slave): arm strobe and DAT0 in, token status and busy tracking out.
interface sdc_dat_resp_rcv_if;
  logic       arm_strb;
  logic       D0_in;
  logic       resp_vld;
  logic [2:0] resp_code;
  logic       crc_ok;
  logic       crc_err;
  logic       wr_err;
  logic       frm_err;
  logic       resp_tmo;
  logic       wr_busy;
  logic       busy_tmo;
  logic       wr_done;

  modport master (
    output arm_strb, D0_in,
    input  resp_vld, resp_code, crc_ok, crc_err, wr_err, frm_err,
    input  resp_tmo, wr_busy, busy_tmo, wr_done
  );

  modport slave (
    input  arm_strb, D0_in,
    output resp_vld, resp_code, crc_ok, crc_err, wr_err, frm_err,
    output resp_tmo, wr_busy, busy_tmo, wr_done
  );
endinterface

// File: rtl/sdc_tmo_cntr.sv
// Clear/enable saturating cycle counter with a compare-to-limit strobe,
// shared by the token wait and the write-busy phases.
module sdc_tmo_cntr #(
  parameter int unsigned CW = 24
) (
  input  logic          sd_clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          hit
);

  always_ff @(posedge sd_clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + CW'(1);
  end

  assign hit = en && (cnt == limit);

endmodule

// File: rtl/sdc_dat_resp_rcv.sv
// SD single-block write response receiver: catches the CRC status token on
// DAT0 after the data block, then tracks card busy until DAT0 is released.
module sdc_dat_resp_rcv
  import sdc_pkg::*;
#(
  parameter int unsigned CW         = 24,
  parameter int unsigned RESP_TMO   = 64,
  parameter int unsigned BUSY_GRACE = 2,
  parameter int unsigned BUSY_TMO   = 24'hFFFFFF
) (
  input  logic                 sd_clk,
  input  logic                 reset,
  sdc_dat_resp_rcv_if.slave    bus
);

  rcv_state_e state;
  logic       d0_z1;
  logic [1:0] bit_idx;
  logic [2:0] resp_code;
  tok_stat_t  stat;
  logic       resp_vld, resp_tmo, wr_busy, busy_tmo, wr_done;

  logic          cnt_en, cnt_clr, cnt_hit, in_grace;
  logic [CW-1:0] cnt, cnt_lim;

  // RESP is the first busy cycle (the one carrying resp_vld), so it counts
  // toward the grace window and the busy timeout just like BUSY.
  assign cnt_en   = state inside {WAIT_ST, RESP, BUSY};
  assign cnt_clr  = !cnt_en;
  assign cnt_lim  = (state == WAIT_ST) ? CW'(RESP_TMO - 1) : CW'(BUSY_TMO - 1);
  assign in_grace = (cnt < CW'(BUSY_GRACE));

  sdc_tmo_cntr #(.CW(CW)) u_cntr (
    .sd_clk (sd_clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (cnt_lim),
    .cnt    (cnt),
    .hit    (cnt_hit)
  );

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state     <= IDLE;
      d0_z1     <= 1'b1;
      bit_idx   <= '0;
      resp_code <= '0;
      stat      <= '0;
      resp_vld  <= 1'b0;
      resp_tmo  <= 1'b0;
      wr_busy   <= 1'b0;
      busy_tmo  <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      d0_z1    <= bus.D0_in;
      resp_vld <= 1'b0;
      resp_tmo <= 1'b0;
      busy_tmo <= 1'b0;
      wr_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.arm_strb) begin
            state     <= WAIT_ST;
            resp_code <= '0;
            stat      <= '0;
          end
        end
        WAIT_ST: begin
          if (!d0_z1) begin
            state   <= STAT;
            bit_idx <= '0;
          end else if (cnt_hit) begin
            resp_tmo <= 1'b1;
            state    <= IDLE;
          end
        end
        STAT: begin
          resp_code <= {resp_code[1:0], d0_z1};
          bit_idx   <= bit_idx + 2'd1;
          if (bit_idx == 2'd2)
            state <= ENDB;
        end
        ENDB: begin
          resp_vld <= 1'b1;
          stat     <= tok_decode(resp_code, d0_z1);
          state    <= RESP;
        end
        RESP, BUSY: begin
          state <= BUSY;
          if (!in_grace && d0_z1) begin
            wr_done <= 1'b1;
            wr_busy <= 1'b0;
            state   <= IDLE;
          end else if (cnt_hit) begin
            busy_tmo <= 1'b1;
            wr_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            wr_busy <= !in_grace;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_vld  = resp_vld;
  assign bus.resp_code = resp_code;
  assign bus.crc_ok    = stat.crc_ok;
  assign bus.crc_err   = stat.crc_err;
  assign bus.wr_err    = stat.wr_err;
  assign bus.frm_err   = stat.frm_err;
  assign bus.resp_tmo  = resp_tmo;
  assign bus.wr_busy   = wr_busy;
  assign bus.busy_tmo  = busy_tmo;
  assign bus.wr_done   = wr_done;

endmodule

// File: doc/sdc_dat_resp_rcv.md
Name: sdc_dat_resp_rcv

Overview:
- Downstream companion of the 1-bit SD data transmitter in the single-block write path.
- Armed by the transmitter's data-transfer-done strobe, it monitors DAT0 for the card's CRC status token: start bit, 3-bit status, end bit.
- It then tracks the card's write-busy period, which ends when DAT0 is released high.
- It reports accept, CRC error, write error, framing error and timeouts to the write controller FSM.

Parameters:
- CW, 24, width of the shared cycle counter.
- RESP_TMO, 64, max sd_clk cycles from arm to token start bit.
- BUSY_GRACE, 2, cycles after end bit during which DAT0 high is not treated as busy release.
- BUSY_TMO, 24'hFFFFFF, max cycles in busy before abort.

Ports:
- sd_clk, input, 1, SD clock; the only clock.
- reset, input, 1, synchronous active-high reset.
- arm_strb, input, 1, 1-cycle strobe from the data transmitter when its last bit (end bit) has gone out.
- D0_in, input, 1, DAT0 from card, pulled up when undriven.
- resp_vld, output, 1, 1-cycle strobe: token received; status outputs valid.
- resp_code, output, 3, received status bits, MSB first on the wire.
- crc_ok, output, 1, level: resp_code==3'b010 and end bit ok.
- crc_err, output, 1, level: resp_code==3'b101.
- wr_err, output, 1, level: resp_code==3'b110.
- frm_err, output, 1, level: end bit was 0, or code is none of the three above.
- resp_tmo, output, 1, 1-cycle strobe: no start bit within RESP_TMO.
- wr_busy, output, 1, level: card holding DAT0 low after token.
- busy_tmo, output, 1, 1-cycle strobe: busy exceeded BUSY_TMO.
- wr_done, output, 1, 1-cycle strobe: busy released; block idle.

Behaviour:
- Reset: all outputs 0 and resp_code=3'b000. FSM to IDLE, counter 0. d0_z1 (input sync register) is set to 1.
- Reset mid-operation aborts immediately with no strobes.
- d0_z1 <= D0_in every cycle. The FSM uses only d0_z1, which adds 1 cycle of input latency.
- IDLE:
  - arm_strb -> WAIT_ST, counter=0.
  - Clear resp_code, crc_ok, crc_err, wr_err and frm_err on arm.
- WAIT_ST:
  - d0_z1==0 -> STAT, bit index=0, counter=0.
  - Else if counter==RESP_TMO-1 -> resp_tmo strobe, IDLE.
  - Else counter+1.
- STAT:
  - Shift d0_z1 into resp_code LSB each cycle (3 cycles total).
  - After the 3rd bit -> ENDB.
- ENDB:
  - Sample end bit.
  - Next cycle: resp_vld=1 and status levels updated together.
  - Then -> BUSY, counter=0.
  - Status levels hold until the next arm_strb or reset.
- BUSY:
  - For counter < BUSY_GRACE, ignore d0_z1 and wr_busy=0.
  - Afterwards, wr_busy = !d0_z1.
  - First cycle with d0_z1==1 after grace -> wr_done strobe, wr_busy=0, IDLE.
  - counter==BUSY_TMO-1 with d0_z1 still 0 -> busy_tmo strobe, wr_busy=0, IDLE.
  - BUSY is entered for every token code, including errors and frm_err. The card may still be busy, so the controller decides the response.
- Counter: CW bits, saturating, and only counts in WAIT_ST and BUSY.
- arm_strb outside IDLE is ignored, with no restart.
- Simultaneous end of grace and DAT0 high: wr_done fires in that same cycle with no wr_busy pulse.
- Guaranteed exclusive per arm: exactly one of {resp_tmo, busy_tmo, wr_done}. resp_vld precedes busy_tmo and wr_done.
- Latency example: the start bit is on D0_in in cycle N. resp_vld is asserted in cycle N+6 (1 sync cycle + start detect + 3 status cycles + end-bit sample).

Decomposition:
- Shared package sdc_pkg holds:
  - state encoding (IDLE, WAIT_ST, STAT, ENDB, RESP, BUSY);
  - token constants TOK_ACCEPT=3'b010, TOK_CRC_ERR=3'b101, TOK_WR_ERR=3'b110.
- One natural sub-module: sdc_tmo_cntr, a CW-bit clear/enable saturating counter with a compare-to-limit strobe output. It is shared by the WAIT_ST and BUSY phases.

Test Plan:
1. Arm, 2 idle-high cycles, then D0 bits 0,0,1,0,1, then low for 100 cycles, then high -> resp_vld with resp_code=010 and crc_ok=1. wr_busy high for 98 cycles (100 − grace). wr_done 1 cycle after D0 rises plus 1 sync cycle.
2. Token 0,1,0,1,1, then busy 10 cycles -> crc_err=1, crc_ok=0, frm_err=0, then wr_done. Token 0,1,1,0,1 -> wr_err=1.
3. Token with end bit 0 (0,0,1,0,0) -> frm_err=1 and resp_vld. Code 3'b111 -> frm_err=1 with crc_ok, crc_err and wr_err all 0.
4. Arm with D0 held high -> resp_tmo strobe exactly RESP_TMO cycles after arm, with no resp_vld. A second arm_strb during WAIT_ST is ignored.
5. BUSY_TMO=200 and D0 held low after a valid token -> busy_tmo at cycle 200 of BUSY, wr_busy drops with it, and no wr_done.
6. Assert reset in STAT, then arm again -> all outputs 0 and resp_code=000. The next clean token decodes normally.
